// File: rtl/tisaradc_deser.sv
// tisaradc_deser: capture stage behind the 8-way time-interleaved SAR ADC.
// Registers the sub-ADC words, removes per-lane capture skew with short delay
// lines, optionally flips each lane MSB (offset-binary to two's complement),
// packs the lanes into one frame and queues frames toward the DSP chain with a
// valid/ready handshake. Dropped frames raise a sticky flag and a counter.
module tisaradc_deser #(
  parameter int WAYS    = 8,
  parameter int BITS    = 9,
  parameter int DEPTH   = 4,
  parameter int MAXSKEW = 3
) (
  input  logic                 clkout_des,
  input  logic                 clkrst_n,
  input  logic [BITS-1:0]      adcin0,
  input  logic [BITS-1:0]      adcin1,
  input  logic [BITS-1:0]      adcin2,
  input  logic [BITS-1:0]      adcin3,
  input  logic [BITS-1:0]      adcin4,
  input  logic [BITS-1:0]      adcin5,
  input  logic [BITS-1:0]      adcin6,
  input  logic [BITS-1:0]      adcin7,
  input  logic                 en,
  input  logic [1:0]           skew0,
  input  logic [1:0]           skew1,
  input  logic [1:0]           skew2,
  input  logic [1:0]           skew3,
  input  logic [1:0]           skew4,
  input  logic [1:0]           skew5,
  input  logic [1:0]           skew6,
  input  logic [1:0]           skew7,
  input  logic                 twos,
  input  logic                 clr,
  output logic [WAYS*BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overflow,
  output logic [15:0]          drop_cnt
);

  localparam int FW = WAYS * BITS;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(MAXSKEW + 1);
  localparam logic [PW-1:0] PRIME_MAX = PW'(MAXSKEW);

  // The port list is fixed at eight lanes; gather them into flat vectors.
  logic [FW-1:0]     adc_all_w;
  logic [2*WAYS-1:0] skew_all_w;
  logic [FW-1:0]     frame_w;
  logic [WAYS-1:0]   skew_chg_w;

  assign adc_all_w  = {adcin7, adcin6, adcin5, adcin4, adcin3, adcin2, adcin1, adcin0};
  assign skew_all_w = {skew7, skew6, skew5, skew4, skew3, skew2, skew1, skew0};

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_lane
    logic [BITS-1:0] cap_q;
    logic [BITS-1:0] dly_q [MAXSKEW];
    logic [1:0]      skew_q;
    logic [1:0]      skew_w;
    logic [BITS-1:0] aligned_w;

    assign skew_w = skew_all_w[gi*2 +: 2];

    // Capture every edge (independent of en) and shift it down the delay line.
    always_ff @(posedge clkout_des or negedge clkrst_n) begin
      if (!clkrst_n) begin
        cap_q  <= '0;
        skew_q <= '0;
        for (int j = 0; j < MAXSKEW; j++) dly_q[j] <= '0;
      end else begin
        cap_q    <= adc_all_w[gi*BITS +: BITS];
        skew_q   <= skew_w;
        dly_q[0] <= cap_q;
        for (int j = 1; j < MAXSKEW; j++) dly_q[j] <= dly_q[j-1];
      end
    end

    // Select the capture delayed by skew cycles; skew 0 is the capture itself.
    always_comb begin
      aligned_w = cap_q;
      for (int j = 1; j <= MAXSKEW; j++) begin
        if (int'(skew_w) == j) aligned_w = dly_q[j-1];
      end
    end

    // MSB flip is applied on the push path, so twos affects the next push.
    assign frame_w[gi*BITS +: BITS] = twos ? {~aligned_w[BITS-1], aligned_w[BITS-2:0]}
                                           : aligned_w;
    assign skew_chg_w[gi] = (skew_q != skew_w);
  end

  // Priming: count enabled edges since the last skew change, saturating.
  logic [PW-1:0] prime_q;
  logic [PW-1:0] prime_d;
  logic          push_req_w;

  // Next priming count: cleared by en low or any lane skew change.
  always_comb begin
    prime_d = prime_q;
    if (!en || (|skew_chg_w)) begin
      prime_d = '0;
    end else if (prime_q != PRIME_MAX) begin
      prime_d = prime_q + PW'(1);
    end
  end

  assign push_req_w = en && (prime_q == PRIME_MAX);

  // Priming counter register.
  always_ff @(posedge clkout_des or negedge clkrst_n) begin
    if (!clkrst_n) prime_q <= '0;
    else           prime_q <= prime_d;
  end

  // Frame FIFO with pointers one bit wider than the address.
  logic [AW:0]   wr_q;
  logic [AW:0]   rd_q;
  logic [AW:0]   wr_d;
  logic [AW:0]   rd_d;
  logic [FW-1:0] mem_q [DEPTH];
  logic          empty_w;
  logic          full_w;
  logic          pop_w;
  logic          push_ok_w;
  logic          drop_w;

  assign empty_w   = (wr_q == rd_q);
  assign full_w    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_w     = !empty_w && out_ready;
  // A pop at the same edge frees the slot the push needs.
  assign push_ok_w = push_req_w && (!full_w || pop_w);
  assign drop_w    = push_req_w && full_w && !pop_w;
  assign wr_d      = push_ok_w ? wr_q + 1'b1 : wr_q;
  assign rd_d      = pop_w ? rd_q + 1'b1 : rd_q;

  // FIFO pointers.
  always_ff @(posedge clkout_des or negedge clkrst_n) begin
    if (!clkrst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clkout_des or negedge clkrst_n) begin
    if (!clkrst_n) begin
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
    end else if (push_ok_w) begin
      mem_q[wr_q[AW-1:0]] <= frame_w;
    end
  end

  assign out_valid = !empty_w;
  assign out_data  = mem_q[rd_q[AW-1:0]];

  // Drop status: clear first, then a same-edge drop counts from zero.
  logic        ovf_q;
  logic        ovf_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next overflow flag and saturating drop count.
  always_comb begin
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (clr) begin
      ovf_d = 1'b0;
      cnt_d = '0;
    end
    if (drop_w) begin
      ovf_d = 1'b1;
      if (cnt_d != 16'hFFFF) cnt_d = cnt_d + 16'd1;
    end
  end

  // Drop status registers.
  always_ff @(posedge clkout_des or negedge clkrst_n) begin
    if (!clkrst_n) begin
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign overflow = ovf_q;
  assign drop_cnt = cnt_q;

endmodule

// File: tb/tb_tisaradc_deser.sv
// Bench for tisaradc_deser: a history-based model predicts every frame from
// the samples, the enable/skew record and a frame queue; directed literals
// pin the model at the key points.
module tb_tisaradc_deser;

  localparam int WAYS    = 8;
  localparam int BITS    = 9;
  localparam int DEPTH   = 4;
  localparam int MAXSKEW = 3;
  localparam int FW      = WAYS * BITS;
  localparam int MAXT    = 2048;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [8:0]    adc [8];
  logic [1:0]    skew [8];
  logic          en;
  logic          twos;
  logic          clr;
  logic          out_ready;
  logic [FW-1:0] out_data;
  logic          out_valid;
  logic          overflow;
  logic [15:0]   drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tisaradc_deser dut (
    .clkout_des(clk),
    .clkrst_n  (rst_n),
    .adcin0    (adc[0]),
    .adcin1    (adc[1]),
    .adcin2    (adc[2]),
    .adcin3    (adc[3]),
    .adcin4    (adc[4]),
    .adcin5    (adc[5]),
    .adcin6    (adc[6]),
    .adcin7    (adc[7]),
    .en        (en),
    .skew0     (skew[0]),
    .skew1     (skew[1]),
    .skew2     (skew[2]),
    .skew3     (skew[3]),
    .skew4     (skew[4]),
    .skew5     (skew[5]),
    .skew6     (skew[6]),
    .skew7     (skew[7]),
    .twos      (twos),
    .clr       (clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [FW-1:0] hist [MAXT];
  logic [15:0]   skew_h [MAXT];
  bit            en_h [MAXT];
  bit            chg_h [MAXT];
  logic [FW-1:0] q [$];
  int            t;
  int            mdrop;
  bit            movf;

  task automatic model_reset();
    t = 0;
    mdrop = 0;
    movf = 0;
    q.delete();
  endtask

  task automatic model_step();
    logic [15:0]   sk;
    logic [15:0]   prev;
    logic [FW-1:0] fr;
    logic [8:0]    w;
    bit            push;
    bit            pop;
    bit            acc;
    bit            drp;
    int            k;
    int            idx;
    if (t >= MAXT) begin
      $display("FAIL model_bound actual=%0d required<%0d", t, MAXT);
      $fatal(1);
    end
    sk = {skew[7], skew[6], skew[5], skew[4], skew[3], skew[2], skew[1], skew[0]};
    for (int i = 0; i < WAYS; i++) hist[t][i*9 +: 9] = adc[i];
    prev = 16'h0;
    if (t > 0) prev = skew_h[t-1];
    chg_h[t]  = (sk != prev);
    skew_h[t] = sk;
    en_h[t]   = en;
    // A push needs the previous MAXSKEW edges enabled with no skew change.
    push = en && (t >= MAXSKEW);
    for (int j = 1; j <= MAXSKEW; j++) begin
      if (t - j >= 0) push = push && en_h[t-j] && !chg_h[t-j];
    end
    // Lane i of the frame is the sample captured 1+skew_i edges ago.
    for (int i = 0; i < WAYS; i++) begin
      k   = int'(sk[i*2 +: 2]);
      idx = t - 1 - k;
      w   = (idx < 0) ? 9'h0 : hist[idx][i*9 +: 9];
      if (twos) w[8] = ~w[8];
      fr[i*9 +: 9] = w;
    end
    pop = (q.size() > 0) && out_ready;
    acc = push && ((q.size() < DEPTH) || pop);
    drp = push && !acc;
    if (clr) begin
      movf  = 0;
      mdrop = 0;
    end
    if (drp) begin
      movf = 1;
      if (mdrop < 65535) mdrop++;
    end
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(fr);
    t++;
  endtask

  // Model update on each edge, compare one time unit later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      chk("valid", FW'(out_valid), FW'(q.size() > 0));
      chk("overflow", FW'(overflow), FW'(movf));
      chk("drop_cnt", FW'(drop_cnt), FW'(mdrop[15:0]));
      if (q.size() > 0) chk("data", out_data, q[0]);
    end
  end

  // ---------------- stimulus ----------------
  int         n;
  int         lead3;
  bit         const_mode;
  logic [8:0] const_val;

  function automatic logic [FW-1:0] frame_of(input int m);
    logic [FW-1:0] f;
    for (int i = 0; i < WAYS; i++) f[i*9 +: 9] = 9'(8 * m + i);
    return f;
  endfunction

  // Ramp value 8*n+i ahead of edge n; lane 3 may lead by lead3 time steps.
  task automatic drive_adc();
    for (int i = 0; i < WAYS; i++) begin
      if (const_mode)  adc[i] = const_val;
      else if (i == 3) adc[i] = 9'(8 * (n + lead3) + i);
      else             adc[i] = 9'(8 * n + i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
    drive_adc();
  endtask

  int n0;
  int q0;
  logic [FW-1:0] all_1ff;
  logic [FW-1:0] all_0ff;

  initial begin
    n = 0; lead3 = 0; const_mode = 0; const_val = '0;
    en = 0; twos = 0; clr = 0; out_ready = 1;
    for (int i = 0; i < WAYS; i++) skew[i] = 2'd0;
    drive_adc();
    for (int i = 0; i < WAYS; i++) begin
      all_1ff[i*9 +: 9] = 9'h1FF;
      all_0ff[i*9 +: 9] = 9'h0FF;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #3;
    chk("rst_valid", FW'(out_valid), FW'(0));
    chk("rst_data", out_data, FW'(0));
    chk("rst_overflow", FW'(overflow), FW'(0));
    chk("rst_drop", FW'(drop_cnt), FW'(0));
    @(negedge clk);
    rst_n = 1;

    // Ramp: edge 0 idle, en from edge 1, first push at edge 4 with sample 3.
    tick();
    en = 1;
    repeat (3) tick();
    chk("ramp_not_primed", FW'(out_valid), FW'(0));
    tick();
    chk("ramp_first_valid", FW'(out_valid), FW'(1));
    chk("ramp_first_frame", out_data, frame_of(3));
    tick();
    chk("ramp_second_frame", out_data, frame_of(4));
    repeat (6) tick();

    // Format conversion.
    const_mode = 1; const_val = 9'h100; twos = 1; drive_adc();
    repeat (2) tick();
    chk("twos_100", out_data, FW'(0));
    const_val = 9'h0FF; drive_adc();
    repeat (2) tick();
    chk("twos_0ff", out_data, all_1ff);
    twos = 0;
    tick();
    chk("bin_0ff", out_data, all_0ff);
    const_mode = 0; drive_adc();
    repeat (2) tick();

    // Skew alignment on lane 3 with re-priming after the change.
    skew[3] = 2'd2; lead3 = 2; drive_adc();
    n0 = n;
    tick();
    chk("skew_push_at_change", FW'(out_valid), FW'(1));
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("skew_repriming", FW'(out_valid), FW'(0));
    end
    tick();
    chk("skew_aligned_a", out_data, frame_of(n0 + 3));
    tick();
    chk("skew_aligned_b", out_data, frame_of(n0 + 4));
    repeat (3) tick();

    // Backpressure: drain, prime, then 10 stalled pushes.
    en = 0;
    repeat (2) tick();
    chk("bp_drained", FW'(out_valid), FW'(0));
    en = 1;
    repeat (3) tick();
    out_ready = 0;
    q0 = n;
    repeat (10) tick();
    chk("bp_overflow", FW'(overflow), FW'(1));
    chk("bp_drop6", FW'(drop_cnt), FW'(6));
    chk("bp_head_oldest", out_data, frame_of(q0 - 1));
    en = 0; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_release_order", out_data, frame_of(q0 + i));
    end
    tick();
    chk("bp_emptied", FW'(out_valid), FW'(0));

    // Full FIFO with simultaneous pop, and clear colliding with a drop.
    clr = 1;
    tick();
    clr = 0;
    chk("clr_drop", FW'(drop_cnt), FW'(0));
    chk("clr_overflow", FW'(overflow), FW'(0));
    en = 1; out_ready = 0;
    repeat (3 + DEPTH) tick();
    tick();
    chk("full_drop1", FW'(drop_cnt), FW'(1));
    out_ready = 1;
    tick();
    chk("full_pop_no_drop", FW'(drop_cnt), FW'(1));
    out_ready = 0; clr = 1;
    tick();
    chk("clr_with_drop", FW'(drop_cnt), FW'(1));
    chk("clr_with_drop_ovf", FW'(overflow), FW'(1));
    clr = 0;
    tick();
    chk("drop_after_clr", FW'(drop_cnt), FW'(2));

    // Reset with 3 frames queued.
    en = 0; out_ready = 1;
    tick();
    out_ready = 0;
    skew[3] = 2'd0; lead3 = 0; drive_adc();
    tick();
    chk("pre_reset_valid", FW'(out_valid), FW'(1));
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_valid", FW'(out_valid), FW'(0));
    chk("async_rst_data", out_data, FW'(0));
    chk("async_rst_drop", FW'(drop_cnt), FW'(0));
    chk("async_rst_ovf", FW'(overflow), FW'(0));
    @(negedge clk);
    @(negedge clk);
    n = 0; drive_adc();
    en = 1; out_ready = 1;
    rst_n = 1;
    repeat (3) tick();
    chk("post_rst_priming", FW'(out_valid), FW'(0));
    tick();
    chk("post_rst_first", FW'(out_valid), FW'(1));
    chk("post_rst_frame", out_data, frame_of(2));
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
